muldiv_unit_with_lock: RTL and testbench

- Shared, lock-arbitrated iterative multiply/divide responder for the superscalar core. It is the target end of the SIC lock protocol (req / issue_id / release / grant) that SICs already use toward the ALU pool and data memory.
- Serves MIPS MULT/MULTU/DIV/DIVU and returns HI/LO to the lock owner.
- Sits beside alu_array_with_lock; one port per SIC.

---
 rtl/muldiv_unit_with_lock.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit_with_lock.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_with_lock.sv
// Lock-arbitrated iterative MIPS multiply/divide unit shared between SIC ports.
// Oldest issue ID wins the lock; the owner runs 32-iteration MULT/MULTU/DIV/DIVU ops.
module muldiv_unit_with_lock #(
  parameter int NUM_PORTS = 2,
  parameter int ID_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          md_req,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] md_issue_id,
  input  logic [NUM_PORTS-1:0]          md_release,
  input  logic [NUM_PORTS-1:0]          md_start,
  input  logic [NUM_PORTS*2-1:0]        md_op,
  input  logic [NUM_PORTS*32-1:0]       md_op_a,
  input  logic [NUM_PORTS*32-1:0]       md_op_b,
  output logic [NUM_PORTS-1:0]          md_grant,
  output logic [NUM_PORTS-1:0]          md_done,
  output logic [NUM_PORTS*32-1:0]       md_hi,
  output logic [NUM_PORTS*32-1:0]       md_lo
);

  localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [OW-1:0] owner;
  logic [1:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   ma_q;
  logic [31:0]   mb_q;
  logic          a_neg_q;
  logic          b_neg_q;
  logic [31:0]   p_hi;
  logic [31:0]   p_lo;
  logic [5:0]    cnt;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  // Age arbitration: smallest issue ID wins, strict compare keeps the lowest index on ties.
  logic [OW-1:0]       arb_idx;
  logic [ID_WIDTH-1:0] best_id;
  logic                found;

  // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    arb_idx = '0;
    best_id = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (md_req[i] && (!found || md_issue_id[i*ID_WIDTH +: ID_WIDTH] < best_id)) begin
        found   = 1'b1;
        best_id = md_issue_id[i*ID_WIDTH +: ID_WIDTH];
        arb_idx = OW'(i);
      end
    end
  end

  // Owner-port view of the request interface.
  logic        own_start;
  logic        own_release;
  logic [1:0]  own_op;
  logic [31:0] own_a;
  logic [31:0] own_b;
  logic        own_a_neg;
  logic        own_b_neg;
  logic [31:0] own_ma;
  logic [31:0] own_mb;

  always_comb begin
    own_start   = md_start[owner];
    own_release = md_release[owner];
    own_op      = md_op[owner*2 +: 2];
    own_a       = md_op_a[owner*32 +: 32];
    own_b       = md_op_b[owner*32 +: 32];
    // op[0] == 0 selects the signed flavours (MULT, DIV).
    own_a_neg   = ~own_op[0] & own_a[31];
    own_b_neg   = ~own_op[0] & own_b[31];
    own_ma      = own_a_neg ? (32'd0 - own_a) : own_a;
    own_mb      = own_b_neg ? (32'd0 - own_b) : own_b;
  end

  // One shift-add multiply step on {p_hi, p_lo}; p_lo starts as the multiplier.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  // One restoring divide step; p_lo starts as the dividend and collects quotient bits.
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, ma_q} : 33'd0);
    mul_next  = {mul_sum, p_lo[31:1]};
    div_shift = {p_hi, p_lo[31]};
    div_diff  = div_shift - {1'b0, mb_q};
    div_ge    = (div_shift >= {1'b0, mb_q});
    div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), p_lo[30:0], div_ge};
  end

  // Sign fixup applied once the magnitudes are finished.
  logic        res_neg;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  always_comb begin
    res_neg  = a_neg_q ^ b_neg_q;
    prod_fix = res_neg ? (64'd0 - {p_hi, p_lo}) : {p_hi, p_lo};
    quot_fix = res_neg ? (32'd0 - p_lo) : p_lo;
    rem_fix  = a_neg_q ? (32'd0 - p_hi) : p_hi;
    if (!op_q[1]) begin
      fin_hi = prod_fix[63:32];
      fin_lo = prod_fix[31:0];
    end else if (mb_q == 32'd0) begin
      fin_hi = a_q;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_hi = rem_fix;
      fin_lo = quot_fix;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so nothing stale can reach the result outputs.
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      ma_q    <= 32'd0;
      mb_q    <= 32'd0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      p_hi    <= 32'd0;
      p_lo    <= 32'd0;
      cnt     <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner <= arb_idx;
            state <= LOCKED;
          end
        end
        LOCKED, DONE: begin
          if (own_release) begin
            state <= IDLE;
          end else if (own_start) begin
            op_q    <= own_op;
            a_q     <= own_a;
            ma_q    <= own_ma;
            mb_q    <= own_mb;
            a_neg_q <= own_a_neg;
            b_neg_q <= own_b_neg;
            p_hi    <= 32'd0;
            p_lo    <= own_op[1] ? own_ma : own_mb;
            cnt     <= 6'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (own_release) begin
            state <= IDLE;
          end else if (cnt == 6'd32) begin
            hi_q  <= fin_hi;
            lo_q  <= fin_lo;
            state <= DONE;
          end else begin
            {p_hi, p_lo} <= op_q[1] ? div_next : mul_next;
            cnt          <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the lock owner sees grant/done/results; everyone else reads zeros.
  always_comb begin
    md_grant = '0;
    md_done  = '0;
    md_hi    = '0;
    md_lo    = '0;
    if (state != IDLE) begin
      md_grant[owner]        = 1'b1;
      md_done[owner]         = (state == DONE);
      md_hi[owner*32 +: 32]  = hi_q;
      md_lo[owner*32 +: 32]  = lo_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit_with_lock.sv
// Directed self-checking bench for muldiv_unit_with_lock: arbitration, lock
// lifetime, arithmetic corner cases, 33-cycle latency and asynchronous reset.
module tb_muldiv_unit_with_lock;

  localparam int NP  = 2;
  localparam int IDW = 16;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       md_req;
  logic [NP*IDW-1:0]   md_issue_id;
  logic [NP-1:0]       md_release;
  logic [NP-1:0]       md_start;
  logic [NP*2-1:0]     md_op;
  logic [NP*32-1:0]    md_op_a;
  logic [NP*32-1:0]    md_op_b;
  logic [NP-1:0]       md_grant;
  logic [NP-1:0]       md_done;
  logic [NP*32-1:0]    md_hi;
  logic [NP*32-1:0]    md_lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit_with_lock #(.NUM_PORTS(NP), .ID_WIDTH(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .md_req      (md_req),
    .md_issue_id (md_issue_id),
    .md_release  (md_release),
    .md_start    (md_start),
    .md_op       (md_op),
    .md_op_a     (md_op_a),
    .md_op_b     (md_op_b),
    .md_grant    (md_grant),
    .md_done     (md_done),
    .md_hi       (md_hi),
    .md_lo       (md_lo)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_operands(input int p, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    md_op[p*2 +: 2]     = op;
    md_op_a[p*32 +: 32] = a;
    md_op_b[p*32 +: 32] = b;
  endtask

  // Launch on owner port p, confirm done is still low after 32 edges and
  // high with the expected results on the 33rd.
  task automatic run_op(input string tag, input int p, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    logic [63:0] ehv;
    logic [63:0] elv;
    logic [63:0] edv;
    ehv = '0;
    elv = '0;
    edv = '0;
    ehv[p*32 +: 32] = ehi;
    elv[p*32 +: 32] = elo;
    edv[p] = 1'b1;
    set_operands(p, op, a, b);
    md_start[p] = 1'b1;
    tick();
    md_start[p] = 1'b0;
    repeat (32) tick();
    check({tag, " done@32"}, 64'(md_done), 64'd0);
    tick();
    check({tag, " done@33"}, 64'(md_done), edv);
    check({tag, " hi"}, md_hi, ehv);
    check({tag, " lo"}, md_lo, elv);
  endtask

  initial begin
    rst         = 1'b1;
    md_req      = '0;
    md_issue_id = '0;
    md_release  = '0;
    md_start    = '0;
    md_op       = '0;
    md_op_a     = '0;
    md_op_b     = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset grant", 64'(md_grant), 64'd0);
    check("reset done", 64'(md_done), 64'd0);
    check("reset hi", md_hi, 64'd0);
    check("reset lo", md_lo, 64'd0);

    // Single requester: grant appears one edge after req is seen.
    md_issue_id[0*IDW +: IDW] = 16'd4;
    md_req[0] = 1'b1;
    check("grant before edge", 64'(md_grant), 64'd0);
    tick();
    check("grant port0", 64'(md_grant), 64'b01);
    md_req[0] = 1'b0;

    run_op("mult -3*5", 0, OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("divu 100/7", 0, OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
    run_op("div -7/2", 0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    md_release[0] = 1'b1;
    tick();
    md_release[0] = 1'b0;
    check("release grant", 64'(md_grant), 64'd0);
    check("release hi", md_hi, 64'd0);

    // Both request in the same cycle; port1 carries the older ID.
    md_issue_id[0*IDW +: IDW] = 16'd5;
    md_issue_id[1*IDW +: IDW] = 16'd3;
    md_req = 2'b11;
    tick();
    check("age arb", 64'(md_grant), 64'b10);
    md_req[1] = 1'b0;

    run_op("div by 0", 1, OP_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("multu max", 1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div min/-1", 1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("mult neg*neg", 1, OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);

    // Release pulse raised here; the FSM is IDLE after this edge and re-arbitrates on the next.
    md_release[1] = 1'b1;
    tick();
    md_release[1] = 1'b0;
    check("handoff gap", 64'(md_grant), 64'd0);
    tick();
    check("handoff grant", 64'(md_grant), 64'b01);
    md_req[0] = 1'b0;

    // Start and release together: release wins, no op runs.
    set_operands(0, OP_MULTU, 32'd2, 32'd3);
    md_start[0]   = 1'b1;
    md_release[0] = 1'b1;
    tick();
    md_start[0]   = 1'b0;
    md_release[0] = 1'b0;
    check("start+release grant", 64'(md_grant), 64'd0);
    repeat (35) tick();
    check("start+release done", 64'(md_done), 64'd0);

    // Equal IDs: lowest port index wins.
    md_issue_id[0*IDW +: IDW] = 16'd7;
    md_issue_id[1*IDW +: IDW] = 16'd7;
    md_req = 2'b11;
    tick();
    check("tie arb", 64'(md_grant), 64'b01);
    md_req = 2'b00;

    // Non-owner start/release during BUSY must not disturb the owner's op.
    set_operands(0, OP_MULTU, 32'd7, 32'd6);
    md_start[0] = 1'b1;
    tick();
    md_start[0] = 1'b0;
    repeat (4) tick();
    set_operands(1, OP_DIVU, 32'd99, 32'd3);
    md_start[1]   = 1'b1;
    md_release[1] = 1'b1;
    tick();
    md_start[1]   = 1'b0;
    md_release[1] = 1'b0;
    repeat (27) tick();
    check("nonowner done@32", 64'(md_done), 64'd0);
    tick();
    check("nonowner done@33", 64'(md_done), 64'b01);
    check("nonowner lo", md_lo, 64'd42);
    check("nonowner hi", md_hi, 64'd0);

    // Abort: release raised in the 10th BUSY cycle.
    set_operands(0, OP_DIV, 32'd1000, 32'd10);
    md_start[0] = 1'b1;
    tick();
    md_start[0] = 1'b0;
    repeat (9) tick();
    md_release[0] = 1'b1;
    tick();
    md_release[0] = 1'b0;
    check("abort grant", 64'(md_grant), 64'd0);
    check("abort lo", md_lo, 64'd0);
    repeat (30) tick();
    check("abort done", 64'(md_done), 64'd0);

    // Asynchronous reset in the middle of BUSY.
    md_issue_id[0*IDW +: IDW] = 16'd1;
    md_req[0] = 1'b1;
    tick();
    check("pre-reset grant", 64'(md_grant), 64'b01);
    set_operands(0, OP_MULT, 32'd3, 32'd3);
    md_start[0] = 1'b1;
    tick();
    md_start[0] = 1'b0;
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async rst grant", 64'(md_grant), 64'd0);
    check("async rst done", 64'(md_done), 64'd0);
    check("async rst hi", md_hi, 64'd0);
    check("async rst lo", md_lo, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post-reset grant", 64'(md_grant), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
